apa102_matrix_driver: RTL

Parametrised serial driver for an APA102-style LED matrix (clock plus data, 32-bit LED words). It holds a 1-bit-per-pixel bitmap written row by row through a simple write port. On each `start` request it streams one complete frame: start frame, one colour word per LED (foreground or background colour chosen by the bitmap), then end frame. It generalises the fixed 8×8 single-glyph strip driver with configurable geometry, serpentine wiring, clock divider, runtime colours/brightness, a start/busy/done handshake and optional scrolling. It sits between the display-content logic and the chip output pins.

---
 rtl/apa102_matrix_driver.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/apa102_matrix_driver.sv
// APA102 LED matrix driver: 1-bpp bitmap streamed as start/pixel/end frames.
// Define APA102_MATRIX_SCROLL_EN to scroll content one column per frame.
module apa102_matrix_driver #(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int SERPENTINE = 1,
  parameter int CLK_DIV    = 1,
  parameter int END_BITS   = 32,
  localparam int AW = ROWS > 1 ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            bm_we,
  input  logic [AW-1:0]   bm_addr,
  input  logic [COLS-1:0] bm_wdata,
  input  logic [23:0]     fg_rgb,
  input  logic [23:0]     bg_rgb,
  input  logic [4:0]      brightness,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            led_clk,
  output logic            led_data
);

  localparam int PW = $clog2(COLS);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(END_BITS > 32 ? END_BITS : 32);

  typedef enum logic [1:0] {
    IDLE, START_FRM, PIXELS, END_FRM
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d, nrow, frow;
  logic [PW-1:0]   pos_q, pos_d, npos, fpos;
  logic [PW-1:0]   col, off_q;
  logic [PW:0]     sum;
  logic [31:0]     sh_q, sh_d, word;
  logic [23:0]     fg_q, fg_d, bg_q, bg_d, rgb;
  logic [4:0]      br_q, br_d;
  logic            clk_q, clk_d;
  logic            done_q, done_d;
  logic            tick, last, pix;
  logic [COLS-1:0] bm_q [ROWS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROWS; i++) bm_q[i] <= '0;
    end else if (bm_we && ({1'b0, bm_addr} < (AW+1)'(ROWS))) begin
      bm_q[bm_addr] <= bm_wdata;
    end
  end

`ifdef APA102_MATRIX_SCROLL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) off_q <= '0;
    else if (done_d)
      off_q <= (off_q == PW'(COLS-1)) ? '0 : off_q + PW'(1);
  end
`else
  assign off_q = '0;
`endif

  // Fetch the pixel of the LED whose word launches next.
  always_comb begin
    last = (row_q == RW'(ROWS-1)) && (pos_q == PW'(COLS-1));
    npos = (pos_q == PW'(COLS-1)) ? '0 : pos_q + PW'(1);
    nrow = (pos_q == PW'(COLS-1)) ? row_q + RW'(1) : row_q;
    frow = (state_q == START_FRM) ? '0 : nrow;
    fpos = (state_q == START_FRM) ? '0 : npos;
    col  = (SERPENTINE != 0 && !frow[0]) ? PW'(COLS-1) - fpos : fpos;
    sum  = {1'b0, col} + {1'b0, off_q};
    if (sum >= (PW+1)'(COLS)) sum = sum - (PW+1)'(COLS);
    pix  = bm_q[frow][sum[PW-1:0]];
    rgb  = pix ? fg_q : bg_q;
    word = {3'b111, br_q, rgb[7:0], rgb[15:8], rgb[23:16]};
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    pos_d   = pos_q;
    sh_d    = sh_q;
    fg_d    = fg_q;
    bg_d    = bg_q;
    br_d    = br_q;
    clk_d   = clk_q;
    done_d  = 1'b0;
    tick    = (div_q == DW'(CLK_DIV-1));
    if (state_q == IDLE) begin
      if (start) begin
        state_d = START_FRM;
        fg_d    = fg_rgb;
        bg_d    = bg_rgb;
        br_d    = brightness;
        div_d   = '0;
        cnt_d   = '0;
        row_d   = '0;
        pos_d   = '0;
        sh_d    = '0;
        clk_d   = 1'b0;
      end
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick && !clk_q) clk_d = 1'b1;
      if (tick && clk_q) begin
        clk_d = 1'b0;
        cnt_d = cnt_q + CW'(1);
        sh_d  = {sh_q[30:0], 1'b1};
        unique case (1'b1)
          state_q == START_FRM: begin
            if (cnt_q == CW'(31)) begin
              state_d = PIXELS;
              cnt_d   = '0;
              sh_d    = word;
            end
          end
          state_q == PIXELS: begin
            if (cnt_q == CW'(31)) begin
              cnt_d = '0;
              if (last) begin
                state_d = END_FRM;
                sh_d    = '1;
              end else begin
                row_d = nrow;
                pos_d = npos;
                sh_d  = word;
              end
            end
          end
          default: begin
            if (cnt_q == CW'(END_BITS-1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
              sh_d    = '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      pos_q   <= '0;
      sh_q    <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      br_q    <= '0;
      clk_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      pos_q   <= pos_d;
      sh_q    <= sh_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      br_q    <= br_d;
      clk_q   <= clk_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign led_clk  = clk_q;
  assign led_data = sh_q[31];

endmodule
